// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised synchronous FIFO with registered read data, level flags and sticky error flags
module fifo_sync_param #(
  parameter int DATA_SIZE       = 8,
  parameter int ADDR_SIZE       = 2,
  parameter int ALMOST_FULL_TH  = 3,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 clear_err,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [ADDR_SIZE:0]   fifo_count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(ALMOST_EMPTY_TH);
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                 push_ok, pop_ok;
  assign full         = count_q == DEPTH_C;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF_C;
  assign almost_empty = count_q <= AE_C;
  assign fifo_count   = count_q;
  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  always_comb begin
    push_ok    = push & (~full | pop);
    pop_ok     = pop & ~empty;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = (push_ok & ~pop_ok) ? count_q + 1'b1 :
                 (pop_ok & ~push_ok) ? count_q - 1'b1 : count_q;
    data_out_d = pop_ok ? mem[rd_ptr_q] : data_out_q;
    valid_d    = pop_ok;
    ovf_d      = (push & ~push_ok) | (~clear_err & ovf_q);
    unf_d      = (pop & empty) | (~clear_err & unf_q);
  end
  always_ff @(posedge clk) if (push_ok) mem[wr_ptr_q] <= data_in;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed stimulus against a queue-based reference model, plus literal spot checks
module tb_fifo_sync_param;
  localparam int DW = 8, AW = 2, DEPTH = 4, AF = 3, AE = 1;
  logic clk = 0, reset = 0, push = 0, pop = 0, clear_err = 0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [AW:0]   fifo_count;
  logic valid_out, full, empty, almost_full, almost_empty, overflow, underflow;
  int checks = 0, errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data = '0;
  logic m_valid = 0, m_ovf = 0, m_unf = 0;

  fifo_sync_param #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in), .clear_err(clear_err),
    .data_out(data_out), .valid_out(valid_out), .fifo_count(fifo_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    q.delete();
    m_data = '0;
    m_valid = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  // One clock: drive inputs, advance the model, return just after the following falling edge.
  task automatic cyc(input logic pu, input logic po, input logic [DW-1:0] din, input logic clr);
    int n;
    logic pa, oa;
    push = pu; pop = po; data_in = din; clear_err = clr;
    n  = q.size();
    pa = pu && (n < DEPTH || po);
    oa = po && n > 0;
    m_valid = oa;
    if (oa) m_data = q.pop_front();
    if (pa) q.push_back(din);
    m_ovf = (pu && !po && n == DEPTH) ? 1'b1 : clr ? 1'b0 : m_ovf;
    m_unf = (po && n == 0) ? 1'b1 : clr ? 1'b0 : m_unf;
    @(negedge clk); #1;
    push = 0; pop = 0; clear_err = 0;
  endtask

  always @(negedge clk) if (reset) begin
    cmp("m_data_out", int'(data_out), int'(m_data));
    cmp("m_valid", int'(valid_out), int'(m_valid));
    cmp("m_count", int'(fifo_count), q.size());
    cmp("m_full", int'(full), int'(q.size() == DEPTH));
    cmp("m_empty", int'(empty), int'(q.size() == 0));
    cmp("m_afull", int'(almost_full), int'(q.size() >= AF));
    cmp("m_aempty", int'(almost_empty), int'(q.size() <= AE));
    cmp("m_ovf", int'(overflow), int'(m_ovf));
    cmp("m_unf", int'(underflow), int'(m_unf));
  end

  task automatic reset_lits(input string tag);
    cmp({tag, "_count"}, int'(fifo_count), 0);
    cmp({tag, "_empty"}, int'(empty), 1);
    cmp({tag, "_aempty"}, int'(almost_empty), 1);
    cmp({tag, "_full"}, int'(full), 0);
    cmp({tag, "_afull"}, int'(almost_full), 0);
    cmp({tag, "_valid"}, int'(valid_out), 0);
    cmp({tag, "_data"}, int'(data_out), 0);
    cmp({tag, "_ovf"}, int'(overflow), 0);
    cmp({tag, "_unf"}, int'(underflow), 0);
  endtask

  initial begin
    logic [DW-1:0] seq [4];
    seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    #12;
    reset_lits("rst");
    reset = 1;
    @(negedge clk); #1;
    // 1: fill
    cyc(1, 0, seq[0], 0); cmp("t1_cnt1", int'(fifo_count), 1); cmp("t1_ae1", int'(almost_empty), 1);
    cyc(1, 0, seq[1], 0); cmp("t1_cnt2", int'(fifo_count), 2); cmp("t1_ae2", int'(almost_empty), 0);
    cyc(1, 0, seq[2], 0); cmp("t1_af3", int'(almost_full), 1); cmp("t1_full3", int'(full), 0);
    cyc(1, 0, seq[3], 0); cmp("t1_full4", int'(full), 1); cmp("t1_cnt4", int'(fifo_count), 4);
    // 2: drain
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'h00, 0);
      cmp("t2_data", int'(data_out), int'(seq[i]));
      cmp("t2_valid", int'(valid_out), 1);
    end
    cmp("t2_empty", int'(empty), 1);
    // 3: overflow
    for (int i = 0; i < 4; i++) cyc(1, 0, seq[i], 0);
    cyc(1, 0, 8'hEE, 0);
    cmp("t3_ovf", int'(overflow), 1); cmp("t3_cnt", int'(fifo_count), 4);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'h00, 0);
      cmp("t3_data", int'(data_out), int'(seq[i]));
    end
    cyc(0, 0, 8'h00, 1);
    cmp("t3_clr", int'(overflow), 0);
    // 4: underflow; set wins over clear
    cyc(0, 1, 8'h00, 0);
    cmp("t4_unf", int'(underflow), 1); cmp("t4_valid", int'(valid_out), 0); cmp("t4_hold", int'(data_out), 8'hD4);
    cyc(0, 1, 8'h00, 1);
    cmp("t4_setwins", int'(underflow), 1);
    cyc(0, 0, 8'h00, 1);
    cmp("t4_clr", int'(underflow), 0);
    cyc(1, 1, 8'h55, 0);
    cmp("t4_cnt", int'(fifo_count), 1); cmp("t4_unf2", int'(underflow), 1); cmp("t4_valid2", int'(valid_out), 0);
    cyc(0, 1, 8'h00, 1);
    cmp("t4_pop55", int'(data_out), 8'h55);
    // 5: push+pop while full, then wrap streaming
    cyc(1, 0, 8'h11, 0); cyc(1, 0, 8'h22, 0); cyc(1, 0, 8'h33, 0); cyc(1, 0, 8'h44, 0);
    cyc(1, 1, 8'h66, 0);
    cmp("t5_old", int'(data_out), 8'h11); cmp("t5_cnt", int'(fifo_count), 4); cmp("t5_ovf", int'(overflow), 0);
    for (int i = 0; i < 2; i++) cyc(0, 1, 8'h00, 0);
    cmp("t5_cnt2", int'(fifo_count), 2);
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'h70 + 8'(i), 0);
    cmp("t5_strm", int'(data_out), 8'h77);
    cyc(0, 1, 8'h00, 0); cyc(0, 1, 8'h00, 0);
    cmp("t5_last", int'(data_out), 8'h79);
    // 6: asynchronous reset mid-stream
    cyc(1, 0, 8'h01, 0); cyc(1, 0, 8'h02, 0); cyc(1, 0, 8'h03, 0);
    cmp("t6_cnt3", int'(fifo_count), 3);
    #2 reset = 0;
    #1 reset_lits("arst");
    mreset();
    @(posedge clk); #1;
    cmp("t6_hold", int'(fifo_count), 0);
    @(negedge clk); #1;
    reset = 1;
    cyc(0, 1, 8'h00, 0);
    cmp("t6_unf", int'(underflow), 1); cmp("t6_valid", int'(valid_out), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
